// File: rtl/decomp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decomp_pkg
//  Description : Shared definitions for the decompression dispatcher:
//                header mode codes, engine indices, input FSM state type and
//                an index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package decomp_pkg;

    // Header mode field codes
    localparam logic [1:0] MODE_BPC = 2'b00;
    localparam logic [1:0] MODE_ZRL = 2'b01;
    localparam logic [1:0] MODE_SR  = 2'b10;

    // Engine slot indices
    localparam int ENG_BPC = 0;
    localparam int ENG_ZRL = 1;
    localparam int ENG_SR  = 2;

    // Input-side packet tracking state
    typedef enum logic [0:0] {
        IN_IDLE = 1'b0,
        IN_PKT  = 1'b1
    } in_state_t;

    // Width needed to index n items; never less than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decomp_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module      : decomp_dispatch_if
//  Description : Bundle of all stream signals around the dispatcher.
//                  input stream : data_i, valid_i, sop_i, eop_i / ready_o
//                  to engines   : eng_data_o, eng_valid_o, eng_sop_o,
//                                 eng_eop_o / eng_ready_i
//                  from engines : eng_data_i, eng_valid_i, eng_sop_i,
//                                 eng_eop_i / eng_ready_o
//                  output stream: data_o, valid_o, sop_o, eop_o / ready_i
//                modport master = dispatcher, modport slave = environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface decomp_dispatch_if #(
    parameter int DATA_W  = 64,
    parameter int NUM_ENG = 3
);
    logic [DATA_W-1:0]         data_i;
    logic                      valid_i;
    logic                      sop_i;
    logic                      eop_i;
    logic                      ready_o;

    logic [NUM_ENG*DATA_W-1:0] eng_data_o;
    logic [NUM_ENG-1:0]        eng_valid_o;
    logic [NUM_ENG-1:0]        eng_sop_o;
    logic [NUM_ENG-1:0]        eng_eop_o;
    logic [NUM_ENG-1:0]        eng_ready_i;

    logic [NUM_ENG*DATA_W-1:0] eng_data_i;
    logic [NUM_ENG-1:0]        eng_valid_i;
    logic [NUM_ENG-1:0]        eng_sop_i;
    logic [NUM_ENG-1:0]        eng_eop_i;
    logic [NUM_ENG-1:0]        eng_ready_o;

    logic [DATA_W-1:0]         data_o;
    logic                      valid_o;
    logic                      sop_o;
    logic                      eop_o;
    logic                      ready_i;

    modport master (
        input  data_i, valid_i, sop_i, eop_i,
        output ready_o,
        output eng_data_o, eng_valid_o, eng_sop_o, eng_eop_o,
        input  eng_ready_i,
        input  eng_data_i, eng_valid_i, eng_sop_i, eng_eop_i,
        output eng_ready_o,
        output data_o, valid_o, sop_o, eop_o,
        input  ready_i
    );

    modport slave (
        output data_i, valid_i, sop_i, eop_i,
        input  ready_o,
        input  eng_data_o, eng_valid_o, eng_sop_o, eng_eop_o,
        output eng_ready_i,
        output eng_data_i, eng_valid_i, eng_sop_i, eng_eop_i,
        input  eng_ready_o,
        input  data_o, valid_o, sop_o, eop_o,
        output ready_i
    );
endinterface
`default_nettype wire

// File: rtl/decomp_order_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : decomp_order_fifo
//  Description : Circular order queue holding the engine index of every
//                in-flight packet, oldest at the head.
//  Ports       : clk, rst_n (async, active-low)
//                i_push/i_wr_data : append an entry
//                i_pop            : drop the head entry
//                o_head           : oldest entry (valid when !o_empty)
//                o_full, o_empty  : occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module decomp_order_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4     // power of two, >= 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wr_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_head,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    // Storage needs no reset: the head is only looked at when non-empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/decomp_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : decomp_dispatch
//  Description : Per-packet dispatcher for the decompression path. The
//                header beat's mode field picks one of NUM_ENG engines
//                (0=BPC, 1=ZRL, 2=SR); the whole packet is routed there with
//                zero latency. Engine results are merged back in
//                sop-acceptance order using an order queue; an engine that
//                finishes early is held off until its packet is at the head.
//  Ports       : clk, rst_n (async, active-low)
//                bus : decomp_dispatch_if.master (input stream, engine
//                      in/out streams, merged output stream)
//                pkt_cnt_o, err_o : only with DECOMP_DISPATCH_STATS_EN
//  Options     : DECOMP_DISPATCH_STATS_EN adds per-engine accepted-packet
//                counters (16-bit wrapping) and a sticky protocol error flag
//                (orphan beat, or sop inside a packet).
//  Revision    : 1.0 - initial release
// ============================================================================
module decomp_dispatch
    import decomp_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int NUM_ENG     = 3,
    parameter int MODE_W      = 2,
    parameter int ORDER_DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    decomp_dispatch_if.master     bus
`ifdef DECOMP_DISPATCH_STATS_EN
    ,
    output logic [NUM_ENG*16-1:0] pkt_cnt_o,
    output logic                  err_o
`endif
);
    localparam int ENG_W = idx_width(NUM_ENG);

    in_state_t         r_state;
    in_state_t         w_state_nxt;
    logic [ENG_W-1:0]  r_cur_sel;
    logic [ENG_W-1:0]  w_dec_sel;
    logic [ENG_W-1:0]  w_route_sel;
    logic [MODE_W-1:0] w_mode;
    logic              w_eng_rdy;
    logic              w_fwd;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_q_full;
    logic              w_q_empty;
    logic [ENG_W-1:0]  w_head;
    logic              w_out_valid;
    logic [DATA_W-1:0] w_out_data;
    logic              w_out_sop;
    logic              w_out_eop;

    // ---------------- header decode: sel = min(mode, NUM_ENG-1) ------------
    assign w_mode = bus.data_i[DATA_W-1 -: MODE_W];

    always_comb begin
        w_dec_sel = ENG_W'(NUM_ENG - 1);
        if (int'(w_mode) < NUM_ENG) begin
            w_dec_sel = ENG_W'(w_mode);
        end
    end

    // In IDLE the beat is a fresh header; inside a packet stick to the latch.
    assign w_route_sel = (r_state == IN_IDLE) ? w_dec_sel : r_cur_sel;

    always_comb begin
        w_eng_rdy = 1'b0;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (w_route_sel == ENG_W'(k)) w_eng_rdy = bus.eng_ready_i[k];
        end
    end

    // ---------------- input FSM ----------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IN_IDLE;
            r_cur_sel <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_cur_sel <= w_dec_sel;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fwd       = 1'b0;
        w_ready     = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            IN_IDLE: begin
                if (bus.valid_i && bus.sop_i) begin
                    // A header needs a free order slot; the engine must not
                    // see valid while the slot is missing.
                    w_fwd   = !w_q_full;
                    w_ready = w_eng_rdy && !w_q_full;
                    if (w_ready) begin
                        w_push = 1'b1;
                        if (!bus.eop_i) w_state_nxt = IN_PKT;
                    end
                end else if (bus.valid_i) begin
                    w_ready = 1'b1;         // orphan beat: swallow it
                end else begin
                    w_ready = !w_q_full;
                end
            end
            IN_PKT: begin
                // Continuation beats already own a slot; full never blocks them.
                w_fwd   = bus.valid_i;
                w_ready = w_eng_rdy;
                if (bus.valid_i && w_eng_rdy && bus.eop_i) w_state_nxt = IN_IDLE;
            end
            default: w_state_nxt = IN_IDLE;
        endcase
    end

    assign bus.ready_o = w_ready;

    // ---------------- order queue --------------------------------------------
    decomp_order_fifo #(
        .WIDTH (ENG_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_wr_data (w_dec_sel),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_q_full),
        .o_empty   (w_q_empty)
    );

    // ---------------- per-engine fan-out and ready return ------------------
    for (genvar k = 0; k < NUM_ENG; k++) begin : g_eng
        logic w_hit;
        assign w_hit = w_fwd && (w_route_sel == ENG_W'(k));
        assign bus.eng_valid_o[k]                    = w_hit;
        assign bus.eng_sop_o[k]                      = w_hit && bus.sop_i;
        assign bus.eng_eop_o[k]                      = w_hit && bus.eop_i;
        assign bus.eng_data_o[k*DATA_W +: DATA_W]    = w_hit ? bus.data_i : '0;
        assign bus.eng_ready_o[k] = !w_q_empty && (w_head == ENG_W'(k)) && bus.ready_i;
    end

    // ---------------- output merge from the head engine --------------------
    always_comb begin
        w_out_valid = 1'b0;
        w_out_data  = '0;
        w_out_sop   = 1'b0;
        w_out_eop   = 1'b0;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (!w_q_empty && (w_head == ENG_W'(k))) begin
                w_out_valid = bus.eng_valid_i[k];
                w_out_data  = bus.eng_data_i[k*DATA_W +: DATA_W];
                w_out_sop   = bus.eng_sop_i[k];
                w_out_eop   = bus.eng_eop_i[k];
            end
        end
    end

    assign w_pop       = w_out_valid && bus.ready_i && w_out_eop;
    assign bus.valid_o = w_out_valid;
    assign bus.data_o  = w_out_data;
    assign bus.sop_o   = w_out_sop;
    assign bus.eop_o   = w_out_eop;

`ifdef DECOMP_DISPATCH_STATS_EN
    // ---------------- statistics -------------------------------------------
    logic [15:0] r_pkt_cnt [NUM_ENG];
    logic        r_err;
    logic        w_orphan;
    logic        w_bad_sop;

    assign w_orphan  = (r_state == IN_IDLE) && bus.valid_i && !bus.sop_i;
    assign w_bad_sop = (r_state == IN_PKT) && bus.valid_i && bus.sop_i && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_ENG; k++) r_pkt_cnt[k] <= '0;
            r_err <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_ENG; k++) begin
                if (w_push && (w_dec_sel == ENG_W'(k))) r_pkt_cnt[k] <= r_pkt_cnt[k] + 16'd1;
            end
            if (w_orphan || w_bad_sop) r_err <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_ENG; k++) begin : g_stat
        assign pkt_cnt_o[k*16 +: 16] = r_pkt_cnt[k];
    end
    assign err_o = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decomp_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decomp_dispatch
//  Description : Self-checking bench for decomp_dispatch. A packet-level
//                reference model (queue of engine indices in arrival order,
//                current-packet engine) predicts every output each cycle.
//                Directed table, hand sequences, then random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_decomp_dispatch;
    import decomp_pkg::*;

    localparam int DW    = 64;
    localparam int NE    = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decomp_dispatch_if #(.DATA_W(DW), .NUM_ENG(NE)) bus ();

`ifdef DECOMP_DISPATCH_STATS_EN
    logic [NE*16-1:0] pkt_cnt;
    logic             err;
`endif

    decomp_dispatch #(
        .DATA_W      (DW),
        .NUM_ENG     (NE),
        .MODE_W      (2),
        .ORDER_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef DECOMP_DISPATCH_STATS_EN
        ,
        .pkt_cnt_o (pkt_cnt),
        .err_o     (err)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model state ---------------------------------
    int oq[$];          // engine index of each in-flight packet, oldest first
    bit m_in_pkt;       // a multi-beat packet is open on the input side
    int m_cur;          // its engine

    function automatic int dec_mode(input logic [1:0] m);
        return (int'(m) > NE - 1) ? NE - 1 : int'(m);
    endfunction

    task automatic chk(input string name, input logic [NE*DW-1:0] act, input logic [NE*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.data_i      = '0;
        bus.valid_i     = 1'b0;
        bus.sop_i       = 1'b0;
        bus.eop_i       = 1'b0;
        bus.eng_ready_i = '1;
        bus.eng_data_i  = '0;
        bus.eng_valid_i = '0;
        bus.eng_sop_i   = '0;
        bus.eng_eop_i   = '0;
        bus.ready_i     = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Called at a negedge with inputs already applied: compare all outputs
    // against the model, step one clock, advance the model.
    task automatic cycle();
        logic              exp_ready;
        logic [NE-1:0]     exp_ev, exp_es, exp_ee, exp_er;
        logic [NE*DW-1:0]  exp_ed;
        logic              exp_vo, exp_so, exp_eo;
        logic [DW-1:0]     exp_do;
        int                sel, route, h;
        bit                fwd, full;
        #1;
        full  = (oq.size() == DEPTH);
        sel   = dec_mode(bus.data_i[DW-1 -: 2]);
        route = sel;
        fwd   = 1'b0;
        if (!m_in_pkt) begin
            if (bus.valid_i && bus.sop_i) begin
                fwd       = !full;
                exp_ready = bus.eng_ready_i[sel] && !full;
            end else if (bus.valid_i) begin
                exp_ready = 1'b1;
            end else begin
                exp_ready = !full;
            end
        end else begin
            route     = m_cur;
            fwd       = bus.valid_i;
            exp_ready = bus.eng_ready_i[m_cur];
        end
        exp_ev = '0; exp_es = '0; exp_ee = '0; exp_ed = '0;
        if (fwd) begin
            exp_ev[route]            = 1'b1;
            exp_es[route]            = bus.sop_i;
            exp_ee[route]            = bus.eop_i;
            exp_ed[route*DW +: DW]   = bus.data_i;
        end
        exp_er = '0; exp_vo = 1'b0; exp_do = '0; exp_so = 1'b0; exp_eo = 1'b0;
        if (oq.size() > 0) begin
            h         = oq[0];
            exp_vo    = bus.eng_valid_i[h];
            exp_do    = bus.eng_data_i[h*DW +: DW];
            exp_so    = bus.eng_sop_i[h];
            exp_eo    = bus.eng_eop_i[h];
            exp_er[h] = bus.ready_i;
        end
        chk("ready_o",      bus.ready_o,     exp_ready);
        chk("eng_valid_o",  bus.eng_valid_o, exp_ev);
        chk("eng_sop_eop",  {bus.eng_sop_o, bus.eng_eop_o}, {exp_es, exp_ee});
        chk("eng_data_o",   bus.eng_data_o,  exp_ed);
        chk("valid_o",      bus.valid_o,     exp_vo);
        chk("data_o",       bus.data_o,      exp_do);
        chk("sop_eop_o",    {bus.sop_o, bus.eop_o}, {exp_so, exp_eo});
        chk("eng_ready_o",  bus.eng_ready_o, exp_er);
        @(posedge clk);
        if (bus.valid_i && exp_ready) begin
            if (!m_in_pkt) begin
                if (bus.sop_i) begin
                    oq.push_back(sel);
                    m_cur    = sel;
                    m_in_pkt = !bus.eop_i;
                end
            end else if (bus.eop_i) begin
                m_in_pkt = 1'b0;
            end
        end
        if (exp_vo && bus.ready_i && exp_eo) void'(oq.pop_front());
        @(negedge clk);
    endtask

    // Let every queued engine return a one-beat result, then confirm empty.
    task automatic drain();
        int guard = 0;
        while (oq.size() > 0 && guard < 40) begin
            idle_inputs();
            bus.eng_valid_i[oq[0]]           = 1'b1;
            bus.eng_sop_i[oq[0]]             = 1'b1;
            bus.eng_eop_i[oq[0]]             = 1'b1;
            bus.eng_data_i[oq[0]*DW +: DW]   = rnd64();
            cycle();
            guard++;
        end
        if (guard >= 40) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: queue still holds %0d entries, required 0", oq.size());
        end
        idle_inputs();
        #1;
        chk("drain_empty_eng_ready", bus.eng_ready_o, '0);
        cycle();
    endtask

    typedef struct {
        logic [1:0]    mode;
        logic [NE-1:0] exp_mask;
        logic          exp_ready;
    } dec_vec_t;

    dec_vec_t tbl[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d_a, d_b, d_c, d_d;

        tbl[0] = '{mode: MODE_BPC, exp_mask: NE'(1 << ENG_BPC), exp_ready: 1'b1};
        tbl[1] = '{mode: MODE_ZRL, exp_mask: NE'(1 << ENG_ZRL), exp_ready: 1'b1};
        tbl[2] = '{mode: MODE_SR,  exp_mask: NE'(1 << ENG_SR),  exp_ready: 1'b1};
        tbl[3] = '{mode: 2'b11,    exp_mask: NE'(1 << ENG_SR),  exp_ready: 1'b1};

        // ---------------- reset ----------------------------------------------
        rst_n = 1'b0;
        idle_inputs();
        oq.delete(); m_in_pkt = 1'b0; m_cur = 0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("reset_ready_o",     bus.ready_o,     1);
        chk("reset_valid_o",     bus.valid_o,     0);
        chk("reset_eng_valid_o", bus.eng_valid_o, 0);
        chk("reset_eng_ready_o", bus.eng_ready_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- decode table: single-beat packets ------------------
        foreach (tbl[i]) begin
            idle_inputs();
            bus.valid_i = 1'b1; bus.sop_i = 1'b1; bus.eop_i = 1'b1;
            bus.data_i  = {tbl[i].mode, 62'($urandom)};
            #1;
            chk("tbl_eng_valid", bus.eng_valid_o, tbl[i].exp_mask);
            chk("tbl_ready",     bus.ready_o,     tbl[i].exp_ready);
            cycle();
        end
        drain();

        // ---------------- ZRL 3-beat packet, 2-beat result, 10-cycle stall ----
        for (int b = 0; b < 3; b++) begin
            idle_inputs();
            bus.valid_i = 1'b1; bus.sop_i = (b == 0); bus.eop_i = (b == 2);
            bus.data_i  = {MODE_ZRL, 62'($urandom)};
            #1;
            chk("zrl_route", bus.eng_valid_o, 3'b010);
            cycle();
        end
        d_a = rnd64(); d_b = rnd64();
        idle_inputs();
        bus.eng_valid_i = 3'b010; bus.eng_sop_i = 3'b010;
        bus.eng_data_i[1*DW +: DW] = d_a;
        #1;
        chk("zrl_beat1_data", bus.data_o, d_a);
        cycle();
        idle_inputs();
        bus.eng_valid_i = 3'b010; bus.eng_eop_i = 3'b010;
        bus.eng_data_i[1*DW +: DW] = d_b;
        bus.ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("stall_valid_o",     bus.valid_o,     1);
            chk("stall_data_o",      bus.data_o,      d_b);
            chk("stall_eng_ready_o", bus.eng_ready_o, 0);
            cycle();
        end
        bus.ready_i = 1'b1;
        #1;
        chk("zrl_beat2_eop",       bus.eop_o,       1);
        chk("zrl_beat2_eng_ready", bus.eng_ready_o, 3'b010);
        cycle();
        idle_inputs();
        #1;
        chk("zrl_queue_empty", bus.eng_ready_o, 0);
        cycle();

        // ---------------- ordering: BPC(2 beats) then SR(1 beat, hdr 11) ------
        idle_inputs();
        bus.valid_i = 1'b1; bus.sop_i = 1'b1; bus.data_i = {MODE_BPC, 62'd5};
        cycle();
        bus.sop_i = 1'b0; bus.eop_i = 1'b1; bus.data_i = rnd64();
        #1;
        chk("bpc_cont_route", bus.eng_valid_o, 3'b001);
        cycle();
        bus.sop_i = 1'b1; bus.eop_i = 1'b1; bus.data_i = {2'b11, 62'd9};
        #1;
        chk("sr_route", bus.eng_valid_o, 3'b100);
        cycle();
        d_c = rnd64(); d_d = rnd64();
        idle_inputs();
        bus.eng_valid_i = 3'b100; bus.eng_sop_i = 3'b100; bus.eng_eop_i = 3'b100;
        bus.eng_data_i[2*DW +: DW] = d_c;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sr_held_eng_ready", bus.eng_ready_o, 3'b001);
            chk("sr_held_valid_o",   bus.valid_o,     0);
            cycle();
        end
        bus.eng_valid_i = 3'b101; bus.eng_sop_i = 3'b101; bus.eng_eop_i = 3'b100;
        bus.eng_data_i[0 +: DW] = d_d;
        #1;
        chk("bpc_first_data", bus.data_o, d_d);
        cycle();
        bus.eng_sop_i = 3'b100; bus.eng_eop_i = 3'b101;
        #1;
        chk("bpc_eop_eng_ready", bus.eng_ready_o, 3'b001);
        cycle();
        bus.eng_valid_i = 3'b100; bus.eng_sop_i = 3'b100; bus.eng_eop_i = 3'b100;
        #1;
        chk("sr_after_eng_ready", bus.eng_ready_o, 3'b100);
        chk("sr_after_data",      bus.data_o,      d_c);
        cycle();
        drain();

        // ---------------- order queue full: 5th sop stalls -------------------
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            bus.valid_i = 1'b1; bus.sop_i = 1'b1; bus.eop_i = 1'b1;
            bus.data_i  = {2'(i % 3), 62'($urandom)};
            cycle();
        end
        idle_inputs();
        bus.valid_i = 1'b1; bus.sop_i = 1'b1; bus.eop_i = 1'b1;
        bus.data_i  = {MODE_ZRL, 62'd77};
        #1;
        chk("full_ready_o", bus.ready_o, 0);
        chk("full_no_fwd",  bus.eng_valid_o, 0);
        cycle();
        bus.eng_valid_i[oq[0]] = 1'b1; bus.eng_eop_i[oq[0]] = 1'b1;
        #1;
        chk("full_pop_cycle_ready_o", bus.ready_o, 0);
        cycle();
        bus.eng_valid_i = '0; bus.eng_eop_i = '0;
        #1;
        chk("after_pop_ready_o", bus.ready_o, 1);
        cycle();
        drain();

        // ---------------- orphan beat ----------------------------------------
        idle_inputs();
        bus.valid_i = 1'b1; bus.data_i = rnd64();
        #1;
        chk("orphan_ready_o",   bus.ready_o,     1);
        chk("orphan_eng_valid", bus.eng_valid_o, 0);
        cycle();
        idle_inputs();
`ifdef DECOMP_DISPATCH_STATS_EN
        #1;
        chk("orphan_err_o", err, 1);
`endif
        cycle();

        // ---------------- reset mid-packet -----------------------------------
        idle_inputs();
        bus.valid_i = 1'b1; bus.sop_i = 1'b1; bus.data_i = {MODE_ZRL, 62'd3};
        cycle();
        idle_inputs();
        bus.eng_valid_i = 3'b010; bus.eng_sop_i = 3'b010;
        rst_n = 1'b0;
        oq.delete(); m_in_pkt = 1'b0;
        #1;
        chk("midrst_valid_o", bus.valid_o, 0);
        chk("midrst_ready_o", bus.ready_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        bus.valid_i = 1'b1; bus.sop_i = 1'b1; bus.eop_i = 1'b1;
        bus.data_i  = {MODE_SR, 62'd1};
        #1;
        chk("postrst_route", bus.eng_valid_o, 3'b100);
        cycle();
        drain();

        // ---------------- random traffic vs model -----------------------------
        for (int n = 0; n < 1500; n++) begin
            bus.data_i      = rnd64();
            bus.valid_i     = ($urandom_range(0, 9) < 7);
            bus.sop_i       = ($urandom_range(0, 9) < 3);
            bus.eop_i       = ($urandom_range(0, 9) < 4);
            bus.eng_ready_i = NE'($urandom);
            bus.eng_data_i  = {rnd64(), rnd64(), rnd64()};
            bus.eng_valid_i = NE'($urandom);
            bus.eng_sop_i   = NE'($urandom);
            bus.eng_eop_i   = NE'($urandom);
            bus.ready_i     = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle_inputs();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
